chip_link_rx: RTL and testbench

CHIP_LINK_RX -- requirements
Module: chip_link_rx

---
 rtl/chip_link_rx_pkg.sv | 30 +++
 rtl/chip_link_rx_if.sv | 24 ++
 rtl/chip_link_rx_flit_fifo.sv | 51 +++++
 rtl/chip_link_rx.sv | 99 +++++++++
 tb/tb_chip_link_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_link_rx_pkg.sv
// Shared chip-link definitions: flit/word sizing helpers and the receive FSM state type.
// Defaults describe a 59-bit flit, 2 connections and 16-bit link words.
package chip_link_rx_pkg;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_dw(input int fw, input int connect);
    return fw + log2(connect);
  endfunction

  function automatic int calc_nword(input int dw, input int chipdata_width);
    return (dw + chipdata_width - 1) / chipdata_width;
  endfunction

  localparam int DW    = calc_dw(59, 2);
  localparam int NWORD = calc_nword(DW, 16);

  typedef enum logic {
    S_IDLE,
    S_ASSEMBLE
  } rx_state_e;

endpackage

// File: rtl/chip_link_rx_if.sv
// Link-word input bus and reassembled-flit output bus of the chip link receiver.
// master = neighbour/downstream side, slave = receiver.
interface chip_link_rx_if #(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int FLIT_W         = chip_link_rx_pkg::DW
);
  logic [CHIPDATA_WIDTH-1:0] recv_data_in;
  logic                      recv_data_valid;
  logic                      recv_data_par;
  logic                      recv_data_ready;
  logic [FLIT_W-1:0]         data_out;
  logic                      data_out_wr;
  logic                      send_fifo_full;

  modport master (
    output recv_data_in, recv_data_valid, recv_data_par, send_fifo_full,
    input  recv_data_ready, data_out, data_out_wr
  );

  modport slave (
    input  recv_data_in, recv_data_valid, recv_data_par, send_fifo_full,
    output recv_data_ready, data_out, data_out_wr
  );
endinterface

// File: rtl/chip_link_rx_flit_fifo.sv
// Generic synchronous FIFO; write visible on the next cycle, head shown combinationally.
// Writes while full and reads while empty are ignored.
module flit_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_dat;
        wptr      <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/chip_link_rx.sv
// Reassembles parity-checked link words (LSW first) into flits; flit writable 1 cycle after last word.
// recv_data_ready follows the registered FIFO occupancy; send_fifo_full holds flits in the FIFO.
module chip_link_rx
  import chip_link_rx_pkg::*;
#(
  parameter int FW             = 59,
  parameter int CONNECT        = 2,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int DEPTH          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  chip_link_rx_if.slave       link,
  output logic                recv_data_err,
  output logic [7:0]          err_cnt
);
  localparam int FLIT_W = calc_dw(FW, CONNECT);
  localparam int WORDS  = calc_nword(FLIT_W, CHIPDATA_WIDTH);
  localparam int WCW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PACK_W = WORDS * CHIPDATA_WIDTH;

  rx_state_e                 state;
  logic [WCW-1:0]            wcnt;
  logic [CHIPDATA_WIDTH-1:0] word_buf [WORDS];
  logic [PACK_W-1:0]         flit_pack;
  logic                      accept;
  logic                      par_ok;
  logic                      last_word;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;

  assign link.recv_data_ready = !fifo_full;
  assign accept    = link.recv_data_valid && !fifo_full;
  assign par_ok    = (link.recv_data_par == ^link.recv_data_in);
  assign last_word = (wcnt == WCW'(WORDS - 1)) && (state == S_ASSEMBLE || WORDS == 1);
  assign push      = accept && par_ok && last_word;
  assign pop       = !fifo_empty && !link.send_fifo_full;
  assign link.data_out_wr = pop;

  // The incoming word fills the slot at wcnt so the flit can be pushed on its accepting edge.
  always_comb begin
    flit_pack = '0;
    for (int i = 0; i < WORDS; i++) begin
      flit_pack[i*CHIPDATA_WIDTH +: CHIPDATA_WIDTH] =
        (WCW'(i) == wcnt) ? link.recv_data_in : word_buf[i];
    end
  end

  generate
    if (PACK_W > FLIT_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^flit_pack[PACK_W-1:FLIT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      recv_data_err <= 1'b0;
      err_cnt       <= '0;
      for (int i = 0; i < WORDS; i++) word_buf[i] <= '0;
    end else begin
      recv_data_err <= 1'b0;
      if (accept) begin
        if (!par_ok) begin
          // A corrupted word poisons the whole flit; resync on the next good word.
          state         <= S_IDLE;
          wcnt          <= '0;
          recv_data_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (last_word) begin
          state <= S_IDLE;
          wcnt  <= '0;
        end else begin
          word_buf[wcnt] <= link.recv_data_in;
          wcnt           <= wcnt + 1'b1;
          state          <= S_ASSEMBLE;
        end
      end
    end
  end

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_flit_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_dat (flit_pack[FLIT_W-1:0]),
    .rd_en  (pop),
    .rd_dat (link.data_out),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );
endmodule

// File: tb/tb_chip_link_rx.sv
// Scenario bench for chip_link_rx: expected flits queued at send time, checked as data_out_wr strobes.
module tb_chip_link_rx;
  localparam int CDW    = 16;
  localparam int FLIT_W = 60;
  localparam int NW     = 4;
  localparam int PAD_W  = NW * CDW - FLIT_W;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              recv_data_err;
  logic [7:0]        err_cnt;
  int                n_checks = 0;
  int                n_fail = 0;
  int                n_flits = 0;
  logic [FLIT_W-1:0] exp_q [$];
  logic [FLIT_W-1:0] mon_exp;
  bit                tog_done;

  chip_link_rx_if #(.CHIPDATA_WIDTH(CDW), .FLIT_W(FLIT_W)) link ();

  chip_link_rx #(
    .FW(59), .CONNECT(2), .CHIPDATA_WIDTH(CDW), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link          (link),
    .recv_data_err (recv_data_err),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && link.data_out_wr === 1'b1) begin
      n_flits++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL flit_unexpected: got data_out=%h, expected no strobe", link.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (link.data_out !== mon_exp) begin
          n_fail++;
          $display("FAIL flit_data: got %h, expected %h", link.data_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [CDW-1:0] w, input bit bad);
    int t = 0;
    link.recv_data_in    = w;
    link.recv_data_par   = (^w) ^ bad;
    link.recv_data_valid = 1'b1;
    @(negedge clk);
    while (link.recv_data_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: recv_data_ready=%b, expected 1 within 2000 cycles", link.recv_data_ready);
    end
    step();
  endtask

  task automatic send_flit(input logic [FLIT_W-1:0] f, input logic [PAD_W-1:0] pad);
    logic [NW*CDW-1:0] p;
    p = {pad, f};
    exp_q.push_back(f);
    for (int i = 0; i < NW; i++) send_word(p[i*CDW +: CDW], 1'b0);
  endtask

  task automatic drain(input int flits_before, input int flits_expected);
    int t = 0;
    link.recv_data_valid = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d flits still pending, expected 0", exp_q.size());
    end
    n_checks++;
    if (n_flits - flits_before != flits_expected) begin
      n_fail++;
      $display("FAIL flit_count: got %0d strobes, expected %0d", n_flits - flits_before, flits_expected);
    end
    step();
  endtask

  task automatic test_reset();
    link.recv_data_in    = '0;
    link.recv_data_valid = 1'b0;
    link.recv_data_par   = 1'b0;
    link.send_fifo_full  = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    n_checks++;
    if (link.recv_data_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", link.recv_data_ready); end
    n_checks++;
    if (link.data_out_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b, expected 0", link.data_out_wr); end
    n_checks++;
    if (recv_data_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, expected 0", recv_data_err); end
    n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d, expected 0", err_cnt); end
    n_checks++;
    if (link.data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: got %h, expected 0", link.data_out); end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int f0 = n_flits;
    exp_q.push_back(60'hD_9ABC_5678_1234);
    send_word(16'h1234, 1'b0);
    send_word(16'h5678, 1'b0);
    send_word(16'h9ABC, 1'b0);
    send_word(16'h000D, 1'b0);
    link.recv_data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (link.data_out_wr !== 1'b1) begin n_fail++; $display("FAIL basic_latency: data_out_wr=%b, expected 1", link.data_out_wr); end
    n_checks++;
    if (link.data_out !== 60'hD_9ABC_5678_1234) begin
      n_fail++;
      $display("FAIL basic_data: got %h, expected %h", link.data_out, 60'hD_9ABC_5678_1234);
    end
    step();
    drain(f0, 1);
  endtask

  task automatic test_parity_err();
    int f0 = n_flits;
    send_word(16'hAAAA, 1'b0);
    send_word(16'h5555, 1'b1);
    link.recv_data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (recv_data_err !== 1'b1) begin n_fail++; $display("FAIL perr_pulse: got %b, expected 1", recv_data_err); end
    n_checks++;
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL perr_cnt: got %0d, expected 1", err_cnt); end
    step();
    @(negedge clk);
    n_checks++;
    if (recv_data_err !== 1'b0) begin n_fail++; $display("FAIL perr_pulse_end: got %b, expected 0", recv_data_err); end
    step();
    send_flit(60'h8_0F0F_1357_2468, 4'h0);
    drain(f0, 1);
  endtask

  task automatic test_backpressure();
    int f0 = n_flits;
    logic [63:0] r;
    link.send_fifo_full = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      r = {$urandom, $urandom};
      send_flit(r[FLIT_W-1:0], 4'h0);
    end
    r = {$urandom, $urandom};
    fork
      send_flit(r[FLIT_W-1:0], 4'h0);
      begin
        @(negedge clk);
        n_checks++;
        if (link.recv_data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b, expected 0", link.recv_data_ready); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (link.recv_data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold: got %b, expected 0", link.recv_data_ready); end
        n_checks++;
        if (link.data_out_wr !== 1'b0) begin n_fail++; $display("FAIL bp_no_strobe: got %b, expected 0", link.data_out_wr); end
        step();
        link.send_fifo_full = 1'b0;
      end
    join
    drain(f0, 5);
  endtask

  task automatic test_toggle();
    int f0 = n_flits;
    tog_done = 1'b0;
    fork
      begin
        logic [63:0] r;
        for (int k = 0; k < 100; k++) begin
          r = {$urandom, $urandom};
          send_flit(r[FLIT_W-1:0], 4'($urandom));
        end
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          step();
          link.send_fifo_full = ~link.send_fifo_full;
        end
      end
    join
    link.send_fifo_full = 1'b0;
    drain(f0, 100);
  endtask

  task automatic test_reset_midflit();
    int f0 = n_flits;
    send_word(16'hBEEF, 1'b0);
    send_word(16'hCAFE, 1'b0);
    link.recv_data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    n_checks++;
    if (link.recv_data_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b, expected 1", link.recv_data_ready); end
    n_checks++;
    if (link.data_out_wr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr: got %b, expected 0", link.data_out_wr); end
    n_checks++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_err_cnt: got %0d, expected 0", err_cnt); end
    n_checks++;
    if (link.data_out !== '0) begin n_fail++; $display("FAIL mid_rst_data_out: got %h, expected 0", link.data_out); end
    #1 rst_n = 1'b1;
    step();
    send_flit(60'h1_2345_6789_ABCD, 4'h0);
    drain(f0, 1);
  endtask

  task automatic test_err_saturate();
    int f0 = n_flits;
    for (int k = 0; k < 254; k++) send_word(16'($urandom), 1'b1);
    link.recv_data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d, expected 254", err_cnt); end
    step();
    for (int k = 0; k < 46; k++) send_word(16'($urandom), 1'b1);
    link.recv_data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d, expected 255", err_cnt); end
    n_checks++;
    if (recv_data_err !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %b, expected 1", recv_data_err); end
    step();
    drain(f0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_backpressure();
    test_toggle();
    test_reset_midflit();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
